// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side load/store controller in front of a single-port,
// word-organised data memory. Sub-word stores use a read-modify-write through
// an internal buffer, and sub-word loads are sign- or zero-extended.
module mem_access_ctrl #(
    parameter int unsigned DM_BYTES = 12288
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [13:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    // Highest legal word base address.
    localparam logic [31:0] MAX_BASE = 32'(DM_BYTES) - 32'd4;

    state_t      state_q, state_d;
    logic        wr_q,    wr_d;
    logic [1:0]  size_q,  size_d;
    logic        uns_q,   uns_d;
    logic [13:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q,   buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic        illegal;

    // Extract and extend the addressed byte/halfword from a memory word.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic        u,
                                             input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = u ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = u ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/halfword of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = old_w;
        case (sz)
            SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Legality of the request currently presented on the inputs.
    always_comb begin
        illegal = 1'b0;
        case (size)
            SZ_BAD:  illegal = 1'b1;
            SZ_HALF: illegal = addr[0];
            SZ_WORD: illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b0;
        endcase
        if (addr > MAX_BASE) begin
            illegal = 1'b1;
        end
    end

    // Next-state and datapath update for the access sequencer.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    uns_d   = uns;
                    addr_d  = addr[13:0];
                    wdata_d = wdata;
                    if (illegal) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        err_d = 1'b0;
                        if (wr && (size == SZ_WORD)) state_d = WRITE;
                        else                         state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d = dm_dout;
                if (wr_q) begin
                    state_d = WRITE;
                end else begin
                    // Extend straight from dm_dout: it is the word being
                    // captured into the buffer on this same edge.
                    rdata_d = load_ext(dm_dout, size_q, uns_q, addr_q[1:0]);
                    state_d = DONE;
                end
            end
            WRITE: begin
                rdata_d = '0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Status and memory-side outputs decoded from the current state.
    always_comb begin
        rdata   = rdata_q;
        ready   = (state_q == DONE);
        err     = (state_q == DONE) && err_q;
        busy    = (state_q != IDLE);
        dm_addr = '0;
        dm_din  = '0;
        // Gated by rst so a reset landing on the write cycle suppresses it.
        dm_we   = (state_q == WRITE) && !rst;
        if ((state_q == READ) || (state_q == WRITE)) begin
            dm_addr = {addr_q[13:2], 2'b00};
        end
        if (state_q == WRITE) begin
            dm_din = store_merge(buf_q, wdata_q, size_q, addr_q[1:0]);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a word
// memory model held in the bench.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err, busy;
    logic [13:0] dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic        dm_we;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [31:0] pl_val = '0;

    int          lat, nwe, rcnt, icnt;
    logic [31:0] din, rd;
    logic        e;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DM_BYTES(12288)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .busy(busy), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr[13:2]];

    always @(posedge clk) begin
        if (pl_en)      mem[pl_idx] <= pl_val;
        else if (dm_we) mem[dm_addr[13:2]] <= dm_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One complete access: returns latency in edges, dm_we cycles, last
    // dm_din seen with dm_we, and err/rdata in the ready cycle.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1; nwe = 0; din = '0;
        while (!ready && lat < 8) begin
            if (dm_we) begin nwe++; din = dm_din; end
            @(posedge clk); #1;
            lat++;
        end
        if (dm_we) nwe++;
        e  = err;
        rd = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_we",    32'(dm_we), 32'd0);
        chk("rst_rdata", rdata,      32'h0);
        chk("rst_addr",  32'(dm_addr), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then word load at 0x10
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nwe", 32'(nwe), 32'd1);
        chk("sw_din", din, 32'hDEADBEEF);
        chk("sw_err", 32'(e), 32'd0);
        chk("sw_rd",  rd, 32'h0);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_nwe", 32'(nwe), 32'd0);
        chk("lw_rd",  rd, 32'hDEADBEEF);
        chk("lw_hold", rdata, 32'hDEADBEEF);

        // Byte store merge at 0x22
        preload(12'd8, 32'h11223344);
        access(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_nwe", 32'(nwe), 32'd1);
        chk("sb_din", din, 32'h11AA3344);
        chk("sb_rd",  rd, 32'h0);
        chk("sb_mem", mem[8], 32'h11AA3344);

        // Sub-word loads with extension from 0x80FF7F01 at 0x30
        preload(12'd12, 32'h80FF7F01);
        access(1'b0, 2'b00, 1'b0, 32'h32, 32'h0);
        chk("lb_s32", rd, 32'hFFFFFFFF);
        chk("lb_lat", 32'(lat), 32'd2);
        access(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
        chk("lhu_32", rd, 32'h000080FF);
        access(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
        chk("lh_30",  rd, 32'h00007F01);
        access(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
        chk("lh_32",  rd, 32'hFFFF80FF);
        access(1'b0, 2'b00, 1'b1, 32'h33, 32'h0);
        chk("lbu_33", rd, 32'h00000080);
        access(1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
        chk("lb_31",  rd, 32'h0000007F);

        // Halfword store into the upper half at 0x32
        access(1'b1, 2'b01, 1'b0, 32'h32, 32'h12345555);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_din", din, 32'h55557F01);
        chk("sh_mem", mem[12], 32'h55557F01);

        // Illegal accesses
        access(1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
        chk("ih_lat", 32'(lat), 32'd1);
        chk("ih_err", 32'(e), 32'd1);
        chk("ih_rd",  rd, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h32, 32'h0);
        chk("iw_lat", 32'(lat), 32'd1);
        chk("iw_err", 32'(e), 32'd1);
        chk("iw_nwe", 32'(nwe), 32'd0);
        access(1'b1, 2'b11, 1'b0, 32'h40, 32'h0);
        chk("is_err", 32'(e), 32'd1);
        chk("is_nwe", 32'(nwe), 32'd0);
        access(1'b1, 2'b10, 1'b0, 32'd12288, 32'h0);
        chk("ib_lat", 32'(lat), 32'd1);
        chk("ib_err", 32'(e), 32'd1);
        chk("ib_nwe", 32'(nwe), 32'd0);
        access(1'b0, 2'b00, 1'b1, 32'd12287, 32'h0);
        chk("ib2_err", 32'(e), 32'd1);

        // Highest legal word base
        preload(12'd3071, 32'hCAFEF00D);
        access(1'b0, 2'b10, 1'b0, 32'd12284, 32'h0);
        chk("top_lat", 32'(lat), 32'd2);
        chk("top_err", 32'(e), 32'd0);
        chk("top_rd",  rd, 32'hCAFEF00D);
        @(posedge clk); @(posedge clk); #1;
        chk("top_hold", rdata, 32'hCAFEF00D);

        // Reset landing on the WRITE cycle of a byte store
        preload(12'd16, 32'h01020304);
        req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h41; wdata = 32'hEE;
        @(posedge clk); #1;
        req = 1'b0;
        chk("mr_busy_rd", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("mr_we_pre", 32'(dm_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_we_rst", 32'(dm_we), 32'd0);
        chk("mr_rdy_wr", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rdy",  32'(ready), 32'd0);
        chk("mr_mem",  mem[16], 32'h01020304);
        chk("mr_rd",   rdata, 32'h0);

        // Reset wins over a simultaneous request
        rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        chk("rp_busy", 32'(busy), 32'd0);

        // Request held high: one access per IDLE visit
        req = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
        rcnt = 0; icnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (ready) rcnt++;
            if (!busy) icnt++;
            if (i == 0) chk("hold_addr", 32'(dm_addr), 32'h10);
        end
        req = 1'b0;
        chk("hold_rdy", 32'(rcnt), 32'd3);
        chk("hold_idle", 32'(icnt), 32'd3);
        chk("hold_rd", rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
